// File: rtl/bitwise_seq_pkg.sv
// Shared types and NOT/AND micro-programs for the bitwise op sequencer.
// Every composite op is expressed as a short walk through a single NOT/AND unit.
package bitwise_seq_pkg;

  typedef enum logic [2:0] {
    OP_NOT  = 3'd0,
    OP_AND  = 3'd1,
    OP_NAND = 3'd2,
    OP_OR   = 3'd3,
    OP_NOR  = 3'd4,
    OP_XOR  = 3'd5,
    OP_RSV6 = 3'd6,
    OP_RSV7 = 3'd7
  } opcode_e;

  typedef enum logic {
    SEL_NOT = 1'b0,
    SEL_AND = 1'b1
  } unit_sel_e;

  typedef enum logic [2:0] {
    REG_RA,
    REG_RB,
    REG_TA,
    REG_TB,
    REG_R
  } reg_sel_e;

  typedef struct packed {
    unit_sel_e sel;
    reg_sel_e  src_a;
    reg_sel_e  src_b;
    reg_sel_e  dst;
    logic      last;
  } step_t;

  localparam int STEPS_NOT  = 1;
  localparam int STEPS_AND  = 1;
  localparam int STEPS_NAND = 2;
  localparam int STEPS_NOR  = 3;
  localparam int STEPS_OR   = 4;
  localparam int STEPS_XOR  = 7;

  function automatic int step_count(opcode_e op);
    case (op)
      OP_NOT:  return STEPS_NOT;
      OP_AND:  return STEPS_AND;
      OP_NAND: return STEPS_NAND;
      OP_NOR:  return STEPS_NOR;
      OP_OR:   return STEPS_OR;
      OP_XOR:  return STEPS_XOR;
      default: return 0;
    endcase
  endfunction

  function automatic step_t mk_step(unit_sel_e sel, reg_sel_e a, reg_sel_e b, reg_sel_e d);
    step_t s;
    s.sel   = sel;
    s.src_a = a;
    s.src_b = b;
    s.dst   = d;
    s.last  = 1'b0;
    return s;
  endfunction

  // NOT steps ignore src_b; it is parked on RA.
  function automatic step_t microcode(opcode_e op, logic [2:0] idx);
    step_t s;
    s = mk_step(SEL_NOT, REG_RA, REG_RA, REG_R);
    case (op)
      OP_NOT: s = mk_step(SEL_NOT, REG_RA, REG_RA, REG_R);
      OP_AND: s = mk_step(SEL_AND, REG_RA, REG_RB, REG_R);
      OP_NAND:
        case (idx)
          3'd0:    s = mk_step(SEL_AND, REG_RA, REG_RB, REG_TA);
          default: s = mk_step(SEL_NOT, REG_TA, REG_RA, REG_R);
        endcase
      OP_NOR:
        case (idx)
          3'd0:    s = mk_step(SEL_NOT, REG_RA, REG_RA, REG_TA);
          3'd1:    s = mk_step(SEL_NOT, REG_RB, REG_RA, REG_TB);
          default: s = mk_step(SEL_AND, REG_TA, REG_TB, REG_R);
        endcase
      OP_OR:
        case (idx)
          3'd0:    s = mk_step(SEL_NOT, REG_RA, REG_RA, REG_TA);
          3'd1:    s = mk_step(SEL_NOT, REG_RB, REG_RA, REG_TB);
          3'd2:    s = mk_step(SEL_AND, REG_TA, REG_TB, REG_TA);
          default: s = mk_step(SEL_NOT, REG_TA, REG_RA, REG_R);
        endcase
      OP_XOR:
        case (idx)
          3'd0:    s = mk_step(SEL_AND, REG_RA, REG_RB, REG_TA);
          3'd1:    s = mk_step(SEL_NOT, REG_TA, REG_RA, REG_TB);
          3'd2:    s = mk_step(SEL_NOT, REG_RA, REG_RA, REG_TA);
          3'd3:    s = mk_step(SEL_NOT, REG_RB, REG_RA, REG_RA);
          3'd4:    s = mk_step(SEL_AND, REG_TA, REG_RA, REG_TA);
          3'd5:    s = mk_step(SEL_NOT, REG_TA, REG_RA, REG_TA);
          default: s = mk_step(SEL_AND, REG_TA, REG_TB, REG_R);
        endcase
      default: s = mk_step(SEL_NOT, REG_RA, REG_RA, REG_R);
    endcase
    s.last = (idx == 3'(step_count(op) - 1));
    return s;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts just after the last winner.
// The pointer moves only when the grant is taken (advance).
module rr_arbiter #(
  parameter int NumReq = 2,
  localparam int IdW = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NumReq-1:0] req,
  input  logic              advance,
  output logic [NumReq-1:0] grant,
  output logic [IdW-1:0]    grant_idx
);

  logic [IdW-1:0] ptr;
  logic [IdW-1:0] cand;
  logic           found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < NumReq; k++) begin
      cand = IdW'((int'(ptr) + 1 + k) % NumReq);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Reset to the last index so requester 0 is searched first.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= IdW'(NumReq - 1);
    end else if (advance) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/bitwise_op_sequencer.sv
// Arbitrates requesters and runs each op as a NOT/AND micro-program on one shared unit.
// Latency is step count + 1 cycles from accept; the response holds until resp_ready.
module bitwise_op_sequencer
  import bitwise_seq_pkg::*;
#(
  parameter int BitWidth = 8,
  parameter int NumReq   = 2,
  localparam int IdW = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NumReq-1:0]          req_valid,
  output logic [NumReq-1:0]          req_ready,
  input  logic [3*NumReq-1:0]        req_op,
  input  logic [BitWidth*NumReq-1:0] req_a,
  input  logic [BitWidth*NumReq-1:0] req_b,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [IdW-1:0]             resp_id,
  output logic [BitWidth-1:0]        resp_data,
  output logic                       resp_err,
  output logic                       unit_sel,
  output logic [BitWidth-1:0]        unit_a,
  output logic [BitWidth-1:0]        unit_b,
  input  logic [BitWidth-1:0]        unit_out
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_e;

  state_e              state, state_nxt;
  logic [BitWidth-1:0] ra, rb, ta, tb, r;
  opcode_e             op;
  logic                err;
  logic [IdW-1:0]      id;
  logic [2:0]          idx;
  step_t               step;

  logic [NumReq-1:0]   arb_req;
  logic [NumReq-1:0]   grant;
  logic [IdW-1:0]      grant_idx;
  logic                accept;
  opcode_e             new_op;
  logic [BitWidth-1:0] new_a, new_b;
  logic                new_rsv;
  logic [BitWidth-1:0] src_a_val, src_b_val;

  assign arb_req   = (state == ST_IDLE) ? req_valid : '0;
  assign accept    = |grant;
  assign req_ready = grant;

  rr_arbiter #(.NumReq(NumReq)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (arb_req),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    new_op  = opcode_e'(req_op[3*int'(grant_idx) +: 3]);
    new_a   = req_a[BitWidth*int'(grant_idx) +: BitWidth];
    new_b   = req_b[BitWidth*int'(grant_idx) +: BitWidth];
    new_rsv = (new_op == OP_RSV6) || (new_op == OP_RSV7);
  end

  assign step = microcode(op, idx);

  always_comb begin
    src_a_val = '0;
    src_b_val = '0;
    case (step.src_a)
      REG_RA:  src_a_val = ra;
      REG_RB:  src_a_val = rb;
      REG_TA:  src_a_val = ta;
      REG_TB:  src_a_val = tb;
      default: src_a_val = r;
    endcase
    case (step.src_b)
      REG_RA:  src_b_val = ra;
      REG_RB:  src_b_val = rb;
      REG_TA:  src_b_val = ta;
      REG_TB:  src_b_val = tb;
      default: src_b_val = r;
    endcase
  end

  // The shared unit sees quiet zeros whenever no micro-step is running.
  always_comb begin
    unit_sel = 1'b0;
    unit_a   = '0;
    unit_b   = '0;
    if (state == ST_EXEC) begin
      unit_sel = step.sel;
      unit_a   = src_a_val;
      unit_b   = src_b_val;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = new_rsv ? ST_RESP : ST_EXEC;
      ST_EXEC: if (step.last) state_nxt = ST_RESP;
      ST_RESP: if (resp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign resp_valid = (state == ST_RESP);
  assign resp_data  = resp_valid ? r : '0;
  assign resp_err   = resp_valid & err;
  assign resp_id    = resp_valid ? id : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      ra    <= '0;
      rb    <= '0;
      ta    <= '0;
      tb    <= '0;
      r     <= '0;
      op    <= OP_NOT;
      err   <= 1'b0;
      id    <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            ra  <= new_a;
            rb  <= new_b;
            ta  <= '0;
            tb  <= '0;
            r   <= '0;
            op  <= new_op;
            err <= new_rsv;
            id  <= grant_idx;
            idx <= '0;
          end
        end
        ST_EXEC: begin
          idx <= idx + 3'd1;
          case (step.dst)
            REG_RA:  ra <= unit_out;
            REG_RB:  rb <= unit_out;
            REG_TA:  ta <= unit_out;
            REG_TB:  tb <= unit_out;
            default: r  <= unit_out;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bitwise_op_sequencer.sv
// Randomized and directed bench for bitwise_op_sequencer against a plain-arithmetic reference model.
module tb_bitwise_op_sequencer;

  localparam int W  = 8;
  localparam int NR = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req_valid = '0;
  logic [NR-1:0] req_ready;
  logic [3*NR-1:0] req_op = '0;
  logic [W*NR-1:0] req_a = '0;
  logic [W*NR-1:0] req_b = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [0:0]    resp_id;
  logic [W-1:0]  resp_data;
  logic          resp_err;
  logic          unit_sel;
  logic [W-1:0]  unit_a, unit_b, unit_out;

  int errors = 0;
  int checks = 0;
  int last_grant = NR - 1;

  always #5 clk = ~clk;

  // External shared logic unit.
  assign unit_out = unit_sel ? (unit_a & unit_b) : ~unit_a;

  bitwise_op_sequencer #(.BitWidth(W), .NumReq(NR)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .unit_sel   (unit_sel),
    .unit_a     (unit_a),
    .unit_b     (unit_b),
    .unit_out   (unit_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_result(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return ~a;
      3'd1:    return a & b;
      3'd2:    return ~(a & b);
      3'd3:    return a | b;
      3'd4:    return ~(a | b);
      3'd5:    return a ^ b;
      default: return 8'h00;
    endcase
  endfunction

  function automatic int ref_steps(input logic [2:0] op);
    case (op)
      3'd0, 3'd1: return 1;
      3'd2:       return 2;
      3'd3:       return 4;
      3'd4:       return 3;
      3'd5:       return 7;
      default:    return 0;
    endcase
  endfunction

  // Per-cycle unit selection, step 0 in bit 0 (1 = AND).
  function automatic logic [6:0] ref_sel(input logic [2:0] op);
    case (op)
      3'd1:    return 7'b0000001;
      3'd2:    return 7'b0000001;
      3'd3:    return 7'b0000100;
      3'd4:    return 7'b0000100;
      3'd5:    return 7'b1010001;
      default: return 7'b0000000;
    endcase
  endfunction

  // Present requests at a negedge, then follow the accepted one through to its handshake.
  task automatic do_txn(input logic [1:0] vld,
                        input logic [2:0] op0, input logic [7:0] a0, input logic [7:0] b0,
                        input logic [2:0] op1, input logic [7:0] a1, input logic [7:0] b1,
                        input int hold);
    int w;
    int n;
    int c;
    logic [2:0] wop;
    logic [7:0] wa, wb, exp_data;
    logic [6:0] pat;
    req_valid = vld;
    req_op    = {op1, op0};
    req_a     = {a1, a0};
    req_b     = {b1, b0};
    #1;
    w = -1;
    for (int k = 0; k < NR; k++) begin
      int cand;
      cand = (last_grant + 1 + k) % NR;
      if (w < 0 && ((vld >> cand) & 2'b01) != 2'b00) w = cand;
    end
    chk("grant", 32'(req_ready), 32'(1 << w));
    last_grant = w;
    wop = (w == 1) ? op1 : op0;
    wa  = (w == 1) ? a1 : a0;
    wb  = (w == 1) ? b1 : b0;
    exp_data = ref_result(wop, wa, wb);
    n   = ref_steps(wop);
    pat = ref_sel(wop);
    for (c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (resp_valid) break;
      if (c - 1 < n) chk("unit_sel", 32'(unit_sel), 32'((pat >> (c - 1)) & 7'd1));
      chk("busy_ready", 32'(req_ready), 32'd0);
    end
    chk("latency", 32'(c), 32'(n + 1));
    if (resp_valid) begin
      for (int h = 0; h <= hold; h++) begin
        if (h == hold) resp_ready = 1'b1;
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_data", 32'(resp_data), 32'(exp_data));
        chk("resp_id", 32'(resp_id), 32'(w));
        chk("resp_err", 32'(resp_err), 32'(wop >= 3'd6));
        chk("resp_ready_block", 32'(req_ready), 32'd0);
        chk("unit_idle", 32'({unit_sel, unit_a, unit_b}), 32'd0);
        @(negedge clk);
      end
      resp_ready = 1'b0;
      chk("resp_drop", 32'(resp_valid), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_unit", 32'({unit_sel, unit_a, unit_b}), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);

    do_txn(2'b01, 3'd1, 8'hF0, 8'h3C, 3'd0, 8'h00, 8'h00, 0);
    do_txn(2'b01, 3'd3, 8'hA5, 8'h0F, 3'd0, 8'h00, 8'h00, 0);
    do_txn(2'b01, 3'd5, 8'hA5, 8'h0F, 3'd0, 8'h00, 8'h00, 0);
    chk("xor_ref", 32'(ref_result(3'd5, 8'hA5, 8'h0F)), 32'hAA);

    for (int i = 0; i < 4; i++)
      do_txn(2'b11, 3'd1, 8'h5A + 8'(i), 8'hFF, 3'd2, 8'h33, 8'h0F + 8'(i), 0);

    do_txn(2'b11, 3'd4, 8'h81, 8'h18, 3'd0, 8'hC3, 8'h00, 3);
    do_txn(2'b01, 3'd6, 8'h12, 8'h34, 3'd0, 8'h00, 8'h00, 1);

    // Abandon an XOR mid-flight; the pointer must return to requester 0.
    req_valid = 2'b01;
    req_op    = {3'd0, 3'd5};
    req_a     = {8'h00, 8'hA5};
    req_b     = {8'h00, 8'h0F};
    #1;
    chk("xor_grant", 32'(req_ready), 32'd1);
    last_grant = 0;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_grant = NR - 1;
    for (int i = 0; i < 10; i++) begin
      chk("abandoned", 32'(resp_valid), 32'd0);
      @(negedge clk);
    end
    do_txn(2'b11, 3'd3, 8'h3C, 8'hC0, 3'd1, 8'hFF, 8'hFF, 0);

    for (int i = 0; i < 40; i++) begin
      do_txn(2'($urandom_range(1, 3)),
             3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
             3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
             int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
